// File: rtl/sram_pkg.sv
// Shared types and constants for the 1R1W pipelined SRAM: controller states
// and the legal READ_LATENCY values.
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic bit read_latency_legal(input int lat);
    return (lat == READ_LATENCY_MIN) || (lat == READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/sram_1r1w_pipe_if.sv
// Request/response bundle for sram_1r1w_pipe: one write port, one read port
// and the init status flag.
interface sram_1r1w_pipe_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int MASK_GRAN = 8
);
  import sram_pkg::*;

  localparam int LANES = WORD_SIZE / MASK_GRAN;

  logic                 write_enable;
  logic [ADDR_SIZE-1:0] write_address;
  logic [WORD_SIZE-1:0] write_data;
  logic [LANES-1:0]     write_mask;
  logic                 read_enable;
  logic [ADDR_SIZE-1:0] read_address;
  logic [WORD_SIZE-1:0] read_data;
  logic                 read_valid;
  logic                 init_busy;

  modport master (
    output write_enable, write_address, write_data, write_mask,
    output read_enable, read_address,
    input  read_data, read_valid, init_busy
  );

  modport slave (
    input  write_enable, write_address, write_data, write_mask,
    input  read_enable, read_address,
    output read_data, read_valid, init_busy
  );

endinterface

// File: rtl/sram_init_sweeper.sv
// INIT/READY controller: after reset, walks every address once emitting a
// zero-write strobe, then parks in READY until the next reset.
module sram_init_sweeper
  import sram_pkg::*;
#(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sweep_we,
  output logic [ADDR_SIZE-1:0] sweep_addr,
  output logic                 init_busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  sram_state_e          state_reg, state_next;
  logic [ADDR_SIZE-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sweep_we   = 1'b0;
    init_busy  = 1'b0;
    if (state_reg == ST_INIT) begin
      sweep_we  = 1'b1;
      init_busy = 1'b1;
      if (cnt_reg == LAST_ADDR) begin
        state_next = ST_READY;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign sweep_addr = cnt_reg;

endmodule

// File: rtl/sram_1r1w_pipe.sv
// 1-read/1-write SRAM with per-lane write mask, zeroing sweep after reset and
// 1- or 2-cycle read pipeline. Define SRAM_1R1W_PIPE_BYPASS_EN for write-first collisions.
module sram_1r1w_pipe
  import sram_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_SIZE    = 4,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  sram_1r1w_pipe_if.slave  bus
);

  localparam int LANES = WORD_SIZE / MASK_GRAN;
  localparam int DEPTH = 1 << ADDR_SIZE;

  if (((WORD_SIZE % MASK_GRAN) != 0) || !read_latency_legal(READ_LATENCY)) begin : g_bad_cfg
    $error("sram_1r1w_pipe: illegal WORD_SIZE/MASK_GRAN/READ_LATENCY combination");
  end

  logic                 sweep_we;
  logic [ADDR_SIZE-1:0] sweep_addr;
  logic                 init_busy;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [ADDR_SIZE-1:0] mem_wr_addr;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 s1_valid_reg;
  logic [WORD_SIZE-1:0] s1_data_reg;

  sram_init_sweeper #(.ADDR_SIZE(ADDR_SIZE)) u_sweeper (
    .clk        (clk),
    .rst        (rst),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .init_busy  (init_busy)
  );

  // User traffic is dropped entirely while the sweep owns the array.
  assign wr_fire     = bus.write_enable && !init_busy;
  assign rd_fire     = bus.read_enable && !init_busy;
  assign mem_wr_addr = sweep_we ? sweep_addr : bus.write_address;

  // One narrow array per mask lane so each lane has its own write enable.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MASK_GRAN-1:0] mem_reg [DEPTH];
    logic                 lane_we;
    logic [MASK_GRAN-1:0] lane_wdata;

    assign lane_we    = sweep_we || (wr_fire && bus.write_mask[gi]);
    assign lane_wdata = sweep_we ? '0 : bus.write_data[gi*MASK_GRAN +: MASK_GRAN];

    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem_reg[mem_wr_addr] <= lane_wdata;
      end
    end

`ifdef SRAM_1R1W_PIPE_BYPASS_EN
    assign rd_word[gi*MASK_GRAN +: MASK_GRAN] =
      (wr_fire && bus.write_mask[gi] && (bus.write_address == bus.read_address))
        ? bus.write_data[gi*MASK_GRAN +: MASK_GRAN]
        : mem_reg[bus.read_address];
`else
    assign rd_word[gi*MASK_GRAN +: MASK_GRAN] = mem_reg[bus.read_address];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_fire;
      if (rd_fire) begin
        s1_data_reg <= rd_word;
      end
    end
  end

  // Data registers only load on a valid beat, so read_data holds between reads.
  if (READ_LATENCY == READ_LATENCY_MAX) begin : g_lat2
    logic                 s2_valid_reg;
    logic [WORD_SIZE-1:0] s2_data_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_reg <= 1'b0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= s1_data_reg;
        end
      end
    end

    assign bus.read_valid = s2_valid_reg;
    assign bus.read_data  = s2_data_reg;
  end else begin : g_lat1
    assign bus.read_valid = s1_valid_reg;
    assign bus.read_data  = s1_data_reg;
  end

  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Directed bench for sram_1r1w_pipe: a latency-1 and a latency-2 instance on a
// shared clock and reset, one task per scenario.
module tb_sram_1r1w_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_1r1w_pipe_if #(.WORD_SIZE(32), .ADDR_SIZE(4), .MASK_GRAN(8)) bus1 ();
  sram_1r1w_pipe_if #(.WORD_SIZE(32), .ADDR_SIZE(4), .MASK_GRAN(8)) bus2 ();

  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(4), .MASK_GRAN(8), .READ_LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(4), .MASK_GRAN(8), .READ_LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.write_enable = 1'b0; bus1.write_address = '0; bus1.write_data = '0; bus1.write_mask = '0;
    bus1.read_enable  = 1'b0; bus1.read_address  = '0;
    bus2.write_enable = 1'b0; bus2.write_address = '0; bus2.write_data = '0; bus2.write_mask = '0;
    bus2.read_enable  = 1'b0; bus2.read_address  = '0;
  endtask

  task automatic wait_init_done(output int cycles);
    cycles = 0;
    while (bus1.init_busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_write1(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus1.write_enable = 1'b1; bus1.write_address = addr; bus1.write_data = data; bus1.write_mask = mask;
    tick();
    bus1.write_enable = 1'b0;
  endtask

  task automatic do_read1(input logic [3:0] addr, output logic v, output logic [31:0] d);
    bus1.read_enable = 1'b1; bus1.read_address = addr;
    tick();
    v = bus1.read_valid;
    d = bus1.read_data;
    bus1.read_enable = 1'b0;
  endtask

  task automatic test_reset();
    int          n;
    logic        v;
    logic [31:0] d;
    rst = 1'b1;
    idle_inputs();
    tick();
    checks++; if (bus1.init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus1.init_busy); end
    checks++; if (bus1.read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus1.read_valid); end
    checks++; if (bus1.read_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus1.read_data); end
    rst = 1'b0;
    wait_init_done(n);
    checks++; if (n != 16) begin errors++; $display("FAIL init_length: got %0d cycles expected 16", n); end
    checks++; if (bus2.init_busy !== 1'b0) begin errors++; $display("FAIL init_length_lat2: got busy %b expected 0", bus2.init_busy); end
    do_read1(4'd5, v, d);
    $display("read addr 5 -> valid %b data %h", v, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL init_read_valid: got %b expected 1", v); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL init_read_data: got %h expected 00000000", d); end
    tick();
    checks++; if (bus1.read_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", bus1.read_valid); end
  endtask

  task automatic test_mask();
    logic        v;
    logic [31:0] d;
    do_write1(4'd3, 32'hDEADBEEF, 4'b1111);
    do_write1(4'd3, 32'h11223344, 4'b0011);
    do_read1(4'd3, v, d);
    $display("masked write addr 3 -> valid %b data %h", v, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL mask_valid: got %b expected 1", v); end
    checks++; if (d !== 32'hDEAD3344) begin errors++; $display("FAIL mask_data: got %h expected DEAD3344", d); end
    tick();
    checks++; if (bus1.read_data !== 32'hDEAD3344) begin errors++; $display("FAIL data_hold: got %h expected DEAD3344", bus1.read_data); end
  endtask

  task automatic test_collision();
    logic        v;
    logic [31:0] d;
    logic [31:0] exp;
`ifdef SRAM_1R1W_PIPE_BYPASS_EN
    exp = 32'hAA55AA55;
`else
    exp = 32'hAAAAAAAA;
`endif
    do_write1(4'd7, 32'hAAAAAAAA, 4'b1111);
    bus1.write_enable = 1'b1; bus1.write_address = 4'd7; bus1.write_data = 32'h55555555; bus1.write_mask = 4'b0101;
    bus1.read_enable  = 1'b1; bus1.read_address  = 4'd7;
    tick();
    bus1.write_enable = 1'b0; bus1.read_enable = 1'b0;
    $display("collision addr 7 -> valid %b data %h", bus1.read_valid, bus1.read_data);
    checks++; if (bus1.read_valid !== 1'b1) begin errors++; $display("FAIL collision_valid: got %b expected 1", bus1.read_valid); end
    checks++; if (bus1.read_data !== exp) begin errors++; $display("FAIL collision_data: got %h expected %h", bus1.read_data, exp); end
    do_read1(4'd7, v, d);
    checks++; if (d !== 32'hAA55AA55) begin errors++; $display("FAIL collision_after: got %h expected AA55AA55", d); end
  endtask

  task automatic test_wrap_back_to_back();
    do_write1(4'd15, 32'h0000000F, 4'b1111);
    bus1.write_enable = 1'b1; bus1.write_address = 4'd0; bus1.write_data = 32'h000000F0; bus1.write_mask = 4'b1111;
    bus1.read_enable  = 1'b1; bus1.read_address  = 4'd15;
    tick();
    $display("read addr 15 -> valid %b data %h", bus1.read_valid, bus1.read_data);
    checks++; if (bus1.read_data !== 32'h0000000F || bus1.read_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_addr15: got %b/%h expected 1/0000000F", bus1.read_valid, bus1.read_data);
    end
    bus1.write_enable = 1'b0;
    bus1.read_address = 4'd0;
    tick();
    bus1.read_enable = 1'b0;
    $display("read addr 0 -> valid %b data %h", bus1.read_valid, bus1.read_data);
    checks++; if (bus1.read_data !== 32'h000000F0 || bus1.read_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_addr0: got %b/%h expected 1/000000F0", bus1.read_valid, bus1.read_data);
    end
  endtask

  task automatic test_latency2();
    logic [31:0] vals [4];
    logic        exp_v;
    vals[0] = 32'h0BAD0000; vals[1] = 32'h12345678; vals[2] = 32'hCAFEF00D; vals[3] = 32'h80000001;
    for (int i = 0; i < 4; i++) begin
      bus2.write_enable = 1'b1; bus2.write_address = 4'(i); bus2.write_data = vals[i]; bus2.write_mask = 4'b1111;
      tick();
    end
    bus2.write_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus2.read_enable  = (k < 4);
      bus2.read_address = 4'(k);
      tick();
      exp_v = (k >= 1) && (k <= 4);
      $display("lat2 cycle %0d -> valid %b data %h", k, bus2.read_valid, bus2.read_data);
      checks++; if (bus2.read_valid !== exp_v) begin errors++; $display("FAIL lat2_valid_%0d: got %b expected %b", k, bus2.read_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus2.read_data !== vals[k-1]) begin errors++; $display("FAIL lat2_data_%0d: got %h expected %h", k, bus2.read_data, vals[k-1]); end
      end
    end
    bus2.read_enable = 1'b0;
  endtask

  task automatic test_reset_mid_ready();
    int          n;
    logic        v;
    logic [31:0] d;
    do_read1(4'd3, v, d);
    checks++; if (d !== 32'hDEAD3344) begin errors++; $display("FAIL pre_reset_data: got %h expected DEAD3344", d); end
    rst = 1'b1;
    #1;
    checks++; if (bus1.read_data !== 32'h0 || bus1.read_valid !== 1'b0 || bus1.init_busy !== 1'b1) begin
      errors++; $display("FAIL async_reset: got data %h valid %b busy %b expected 00000000/0/1", bus1.read_data, bus1.read_valid, bus1.init_busy);
    end
    tick();
    rst = 1'b0;
    wait_init_done(n);
    checks++; if (n != 16) begin errors++; $display("FAIL reinit_length: got %0d expected 16", n); end
    do_read1(4'd3, v, d);
    $display("after re-init addr 3 -> valid %b data %h", v, d);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reinit_addr3: got %b/%h expected 1/00000000", v, d); end
    do_read1(4'd7, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reinit_addr7: got %b/%h expected 1/00000000", v, d); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    int spurious;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (bus1.init_busy !== 1'b1) begin errors++; $display("FAIL mid_init_busy: got %b expected 1", bus1.init_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus1.read_enable = 1'b1; bus1.read_address = 4'd5;
    bus2.read_enable = 1'b1; bus2.read_address = 4'd5;
    n = 0;
    spurious = 0;
    while (bus1.init_busy && n < 100) begin
      tick();
      n++;
      if (bus1.read_valid !== 1'b0 || bus2.read_valid !== 1'b0) spurious++;
    end
    bus1.read_enable = 1'b0;
    bus2.read_enable = 1'b0;
    $display("mid-init reset -> busy cycles %0d, stray valids %0d", n, spurious);
    checks++; if (n != 16) begin errors++; $display("FAIL restart_length: got %0d expected 16", n); end
    checks++; if (spurious != 0) begin errors++; $display("FAIL init_read_ignored: got %0d valid pulses expected 0", spurious); end
    tick();
    checks++; if (bus1.read_valid !== 1'b0) begin errors++; $display("FAIL post_init_idle: got %b expected 0", bus1.read_valid); end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_collision();
    test_wrap_back_to_back();
    test_latency2();
    test_reset_mid_ready();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_pipe.md
SRAM_1R1W_PIPE -- requirements
Module: sram_1r1w_pipe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, address width; depth = 2^ADDR_SIZE.
REQ-003 SHALL have parameter MASK_GRAN, default 8, bits per write-mask lane; LANES = WORD_SIZE/MASK_GRAN.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from read_enable to read_valid; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port write_enable  input  1  write request.
REQ-008 SHALL have port write_address  input  ADDR_SIZE  write location.
REQ-009 SHALL have port write_data  input  WORD_SIZE  write word.
REQ-010 SHALL have port write_mask  input  LANES  per-lane write enable, bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].
REQ-011 SHALL have port read_enable  input  1  read request.
REQ-012 SHALL have port read_address  input  ADDR_SIZE  read location.
REQ-013 SHALL have port read_data  output  WORD_SIZE  registered read word.
REQ-014 SHALL have port read_valid  output  1  one-cycle pulse, read_data valid.
REQ-015 SHALL have port init_busy  output  1  high while init sweep runs.

Function
REQ-016 SHALL implement two states: INIT (clears memory) and READY (normal operation).
REQ-017 SHALL, in INIT, write all-zero to address sweep_cnt each cycle, sweep_cnt from 0 to 2^ADDR_SIZE-1, then enter READY; INIT lasts exactly 2^ADDR_SIZE cycles.
REQ-018 SHALL ignore write_enable and read_enable while init_busy is high (no write, no read_valid).
REQ-019 SHALL, in READY with write_enable, update only lanes whose write_mask bit is 1; unmasked lanes keep prior content.
REQ-020 SHALL, in READY with read_enable, assert read_valid exactly READ_LATENCY cycles later with memory[read_address] as sampled at the request edge.
REQ-021 SHALL hold read_data at its last value when read_valid is low.
REQ-022 SHALL accept one read and one write per cycle, back-to-back, no stalls.
REQ-023 SHALL treat addresses modulo 2^ADDR_SIZE; address 2^ADDR_SIZE-1 followed by 0 needs no special handling.
REQ-024 SHALL resolve same-cycle read and write to the same address per REQ-031/REQ-032.
REQ-025 SHALL fail elaboration if WORD_SIZE % MASK_GRAN != 0 or READ_LATENCY not in {1,2}.

Reset
REQ-026 SHALL, on rst assertion, immediately set state INIT, sweep_cnt 0, init_busy 1, read_valid 0, read_data 0, and discard in-flight reads.
REQ-027 SHALL, on rst mid-INIT, restart the sweep at address 0 after release.
REQ-028 SHALL, on rst mid-READY, lose memory content via the following full sweep.

Configuration
REQ-029 SHALL use macro SRAM_1R1W_PIPE_BYPASS_EN to select collision behaviour.
REQ-030 SHALL leave write and read behaviour outside collisions identical in both builds.
REQ-031 SHALL, with the macro defined, return on collision the new data in masked-on lanes and old data in masked-off lanes (write-first).
REQ-032 SHALL, without the macro, return on collision the full old word (read-first), with no bypass logic.

Structure
REQ-033 SHALL place the INIT/READY state enum and the READ_LATENCY legal-value constants in shared package sram_pkg.
REQ-034 SHALL implement the state machine and sweep counter in sub-module sram_init_sweeper (outputs sweep write enable, sweep address, init_busy).

Verification (WORD_SIZE=32, ADDR_SIZE=4, MASK_GRAN=8)
REQ-035 SHALL check: release rst -> init_busy high 16 cycles then low; read addr 5 -> 0x00000000, read_valid one cycle later.
REQ-036 SHALL check: write 0xDEADBEEF addr 3 mask 4'b1111, then 0x11223344 mask 4'b0011 -> read addr 3 returns 0xDEAD3344.
REQ-037 SHALL check: addr 7 holds 0xAAAAAAAA; same-cycle read and write 0x55555555 mask 4'b0101 -> 0xAA55AA55 with macro, 0xAAAAAAAA without.
REQ-038 SHALL check: READ_LATENCY=2, reads addr 0,1,2,3 on consecutive cycles -> four consecutive read_valid pulses starting 2 cycles after first request, data in order.
REQ-039 SHALL check: rst pulsed at sweep_cnt 9 -> init_busy high 16 full cycles after release; read requested during INIT -> no read_valid.
REQ-040 SHALL check: write 0x0000000F addr 15 then 0x000000F0 addr 0 -> reads addr 15 and 0 return 0x0000000F and 0x000000F0.
